// File: rtl/minterm_chk_pkg.sv
// -----------------------------------------------------------------------------
// minterm_chk_pkg
// Shared definitions for the minterm response checker:
//   - chk_state_t   : checker FSM states (IDLE, RUN, DRAIN, DONE), 2-bit encoded
//   - VW            : width of an applied vector {a,b,c,d}
//   - TRUTH_DEFAULT : reference truth table, bit i = f(i), a is the MSB of i
//   - dl_entry_t    : one delay-line slot, {valid, vector}
// -----------------------------------------------------------------------------
package minterm_chk_pkg;

  localparam int VW = 4;

  // f = 1 for minterms 0, 4, 5, 8, 10, 12
  localparam logic [15:0] TRUTH_DEFAULT = 16'h1531;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  typedef struct packed {
    logic          vld;
    logic [VW-1:0] vec;
  } dl_entry_t;

endpackage

// File: rtl/chk_delay_line.sv
// -----------------------------------------------------------------------------
// chk_delay_line
// LAT-deep shift register of {valid, vec} that realigns each accepted vector
// with the DUT output it produced. With LAT = 0 the entry passes straight
// through and no registers are built.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   clr         : synchronous clear of all slots (run restart / abort)
//   push        : entry entering the line this cycle
//   head        : entry leaving the line (the one being compared this cycle)
//   any_valid   : a valid entry is still in flight behind the head, i.e. the
//                 line will not be empty after this cycle's compare
// -----------------------------------------------------------------------------
module chk_delay_line
  import minterm_chk_pkg::*;
#(
  parameter int LAT = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clr,
  input  dl_entry_t push,
  output dl_entry_t head,
  output logic      any_valid
);

  if (LAT == 0) begin : g_bypass
    assign head      = push;
    assign any_valid = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, clr};
  end else begin : g_shift
    dl_entry_t stage [LAT];

    // NOTE: the whole line, payload included, is cleared here; it is only a
    // few flops, and a cleared payload keeps the head free of stale vectors.
    always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
        for (int i = 0; i < LAT; i++) stage[i] <= '0;
      end else begin
        stage[0] <= push;
        for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
      end
    end

    assign head = stage[LAT-1];

    // The head slot is excluded: it is consumed by this cycle's compare.
    // NOTE: the default assignment up front keeps this block free of latches.
    always_comb begin
      any_valid = 1'b0;
      for (int i = 0; i < LAT - 1; i++) any_valid = any_valid | stage[i].vld;
    end
  end

endmodule

// File: rtl/minterm_resp_checker.sv
// -----------------------------------------------------------------------------
// minterm_resp_checker
// Receiving end of a {a,b,c,d} vector stream driven into a minterm function
// block. Each accepted vector is realigned by LAT cycles with the block's
// output, compared against TRUTH, and counted as a pass or a fail. The first
// failing vector is captured, and done rises after NUM_VEC vectors have been
// accepted and all in-flight samples have been checked.
//
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : one-cycle pulse, starts a run and clears results
//                     (honoured in IDLE and DONE only)
//   vec_valid       : a vector is applied to the DUT this cycle
//   vec_in          : applied vector {a,b,c,d}
//   dut_out         : DUT function output
//   busy            : high in RUN and DRAIN
//   done            : high in DONE
//   pass_cnt        : matching samples, saturating
//   fail_cnt        : mismatching samples, saturating
//   first_fail_vld  : first failure captured
//   first_fail_vec  : vector of the first failure
//   first_fail_got  : dut_out seen at the first failure
//
// Build option: MINTERM_CHK_STOP_ON_FAIL_EN -- when defined, the first mismatch
// ends the run on the next edge, discarding in-flight entries.
// -----------------------------------------------------------------------------
module minterm_resp_checker
  import minterm_chk_pkg::*;
#(
  parameter logic [15:0] TRUTH   = TRUTH_DEFAULT,
  parameter int          LAT     = 0,
  parameter int          NUM_VEC = 19,
  parameter int          CW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          vec_valid,
  input  logic [VW-1:0] vec_in,
  input  logic          dut_out,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt,
  output logic          first_fail_vld,
  output logic [VW-1:0] first_fail_vec,
  output logic          first_fail_got
);

  localparam logic [7:0]    LAST_IDX = 8'(NUM_VEC - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  chk_state_t state;
  logic [7:0] acc_cnt;

  logic       restart;
  logic       accept;
  logic       cmp_vld;
  logic       match;
  logic       stop_fail;
  logic       dl_any_valid;
  dl_entry_t  push;
  dl_entry_t  head;

  assign busy    = (state == RUN) || (state == DRAIN);
  assign done    = (state == DONE);
  assign restart = start && ((state == IDLE) || (state == DONE));
  assign accept  = (state == RUN) && vec_valid;
  assign push    = '{vld: accept, vec: vec_in};

  // With LAT = 0 the head is the live input, so this also covers the
  // same-cycle compare.
  assign cmp_vld = head.vld && busy;
  assign match   = (dut_out == TRUTH[head.vec]);

`ifdef MINTERM_CHK_STOP_ON_FAIL_EN
  assign stop_fail = cmp_vld && !match;
`else
  assign stop_fail = 1'b0;
`endif

  chk_delay_line #(
    .LAT (LAT)
  ) u_delay_line (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (restart || stop_fail),
    .push      (push),
    .head      (head),
    .any_valid (dl_any_valid)
  );

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      acc_cnt        <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
      first_fail_got <= 1'b0;
    end else if (restart) begin
      // A vec_valid arriving with start is dropped: accept is RUN-only.
      state          <= RUN;
      acc_cnt        <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
      first_fail_got <= 1'b0;
    end else begin
      if (cmp_vld) begin
        if (match) begin
          if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
        end else begin
          if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
          if (!first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_vec <= head.vec;
            first_fail_got <= dut_out;
          end
        end
      end

      case (state)
        RUN: begin
          if (stop_fail) begin
            state <= DONE;
          end else if (vec_valid) begin
            acc_cnt <= acc_cnt + 8'd1;
            if (acc_cnt == LAST_IDX) state <= DRAIN;
          end
        end
        // Leaves once the entry at the head is the last one in flight, so
        // the final compare and the move to DONE share an edge.
        DRAIN: begin
          if (stop_fail || !dl_any_valid) state <= DONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_minterm_resp_checker.sv
// -----------------------------------------------------------------------------
// tb_minterm_resp_checker
// Four checker instances sharing one clock and reset:
//   0: LAT=0 NUM_VEC=19 CW=8  correct DUT model
//   1: LAT=2 NUM_VEC=19 CW=8  DUT model with f(4) stuck at 0
//   2: LAT=1 NUM_VEC=5  CW=2  correct, then faulty at vector 11
//   3: LAT=0 NUM_VEC=3  CW=8  inverted DUT model
// Each accepted vector pushes its expected outcome to a scoreboard tagged with
// the edge at which the checker must count it; entries are popped at that
// edge and folded into per-instance expected counters, which are then compared
// against the DUT every cycle together with done/busy/first-fail outputs.
// -----------------------------------------------------------------------------
module tb_minterm_resp_checker;

  localparam int N   = 4;
  localparam int INF = 1 << 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start     [N];
  logic       vec_valid [N];
  logic [3:0] vec_in    [N];
  logic       dut_out   [N];
  logic       busy      [N];
  logic       done      [N];
  logic       ffv       [N];
  logic [3:0] ffvec     [N];
  logic       ffgot     [N];

  logic [7:0] pass_a, fail_a, pass_b, fail_b, pass_d, fail_d;
  logic [1:0] pass_c, fail_c;

  int lat_c [N] = '{0, 2, 1, 0};
  int nv_c  [N] = '{19, 19, 5, 3};
  int max_c [N] = '{255, 255, 3, 255};
  int fault_mode [N];

  logic [15:0] truth;
  logic [3:0]  hist [N][2];

  // ---------------- DUT instances ----------------
  minterm_resp_checker #(.LAT(0), .NUM_VEC(19), .CW(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .vec_valid(vec_valid[0]),
    .vec_in(vec_in[0]), .dut_out(dut_out[0]), .busy(busy[0]), .done(done[0]),
    .pass_cnt(pass_a), .fail_cnt(fail_a), .first_fail_vld(ffv[0]),
    .first_fail_vec(ffvec[0]), .first_fail_got(ffgot[0]));

  minterm_resp_checker #(.LAT(2), .NUM_VEC(19), .CW(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .vec_valid(vec_valid[1]),
    .vec_in(vec_in[1]), .dut_out(dut_out[1]), .busy(busy[1]), .done(done[1]),
    .pass_cnt(pass_b), .fail_cnt(fail_b), .first_fail_vld(ffv[1]),
    .first_fail_vec(ffvec[1]), .first_fail_got(ffgot[1]));

  minterm_resp_checker #(.LAT(1), .NUM_VEC(5), .CW(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .vec_valid(vec_valid[2]),
    .vec_in(vec_in[2]), .dut_out(dut_out[2]), .busy(busy[2]), .done(done[2]),
    .pass_cnt(pass_c), .fail_cnt(fail_c), .first_fail_vld(ffv[2]),
    .first_fail_vec(ffvec[2]), .first_fail_got(ffgot[2]));

  minterm_resp_checker #(.LAT(0), .NUM_VEC(3), .CW(8)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .vec_valid(vec_valid[3]),
    .vec_in(vec_in[3]), .dut_out(dut_out[3]), .busy(busy[3]), .done(done[3]),
    .pass_cnt(pass_d), .fail_cnt(fail_d), .first_fail_vld(ffv[3]),
    .first_fail_vec(ffvec[3]), .first_fail_got(ffgot[3]));

  // ---------------- function-block models ----------------
  function automatic logic dut_model(int mode, logic [3:0] v);
    case (mode)
      1:       return (v == 4'd4) ? 1'b0 : truth[v];
      2:       return ~truth[v];
      3:       return (v == 4'd11) ? ~truth[v] : truth[v];
      default: return truth[v];
    endcase
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      hist[k][0] <= vec_in[k];
      hist[k][1] <= hist[k][0];
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      dut_out[k] = dut_model(fault_mode[k],
                             (lat_c[k] == 0) ? vec_in[k] :
                             (lat_c[k] == 1) ? hist[k][0] : hist[k][1]);
    end
  end

  // ---------------- scoreboard / expected state ----------------
  typedef struct {
    int         k;
    int         due;
    logic [3:0] vec;
    logic       got;
    logic       match;
  } exp_t;

  exp_t       sb [$];
  int         cyc;
  int         n_checks;
  int         n_err;
  int         m_pass [N];
  int         m_fail [N];
  int         m_acc  [N];
  int         done_due [N];
  bit         started [N];
  bit         stopped [N];
  bit         pend_start [N];
  bit         m_ffv [N];
  logic [3:0] m_ffvec [N];
  logic       m_ffgot [N];

  function automatic logic [7:0] obs_pass(int k);
    case (k)
      0:       return pass_a;
      1:       return pass_b;
      2:       return {6'd0, pass_c};
      default: return pass_d;
    endcase
  endfunction

  function automatic logic [7:0] obs_fail(int k);
    case (k)
      0:       return fail_a;
      1:       return fail_b;
      2:       return {6'd0, fail_c};
      default: return fail_d;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic clear_model(int k);
    m_pass[k]   = 0;
    m_fail[k]   = 0;
    m_acc[k]    = 0;
    done_due[k] = INF;
    stopped[k]  = 1'b0;
    m_ffv[k]    = 1'b0;
    m_ffvec[k]  = 4'd0;
    m_ffgot[k]  = 1'b0;
  endtask

  function automatic bit m_done(int k);
    return started[k] && (cyc >= done_due[k]);
  endfunction

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      check($sformatf("i%0d pass_cnt", k), 32'(obs_pass(k)), 32'(m_pass[k]));
      check($sformatf("i%0d fail_cnt", k), 32'(obs_fail(k)), 32'(m_fail[k]));
      check($sformatf("i%0d done", k), 32'(done[k]), 32'(m_done(k)));
      check($sformatf("i%0d busy", k), 32'(busy[k]), 32'(started[k] && !m_done(k)));
      check($sformatf("i%0d ff_vld", k), 32'(ffv[k]), 32'(m_ffv[k]));
      check($sformatf("i%0d ff_vec", k), 32'(ffvec[k]), 32'(m_ffvec[k]));
      check($sformatf("i%0d ff_got", k), 32'(ffgot[k]), 32'(m_ffgot[k]));
    end
  endtask

  // Advance one clock edge and fold in everything the checker does there.
  task automatic step();
    bit   rst_now;
    bit   drop [N];
    exp_t keep [$];
    int   k;
    rst_now = !rst_n;
    for (int j = 0; j < N; j++) drop[j] = 1'b0;
    @(posedge clk);
    cyc++;
    if (rst_now) begin
      sb.delete();
      for (int j = 0; j < N; j++) begin
        clear_model(j);
        started[j]    = 1'b0;
        pend_start[j] = 1'b0;
      end
    end else begin
      foreach (sb[i]) begin
        k = sb[i].k;
        if (drop[k]) continue;
        if (sb[i].due != cyc) begin
          keep.push_back(sb[i]);
        end else if (sb[i].match) begin
          if (m_pass[k] < max_c[k]) m_pass[k]++;
        end else begin
          if (m_fail[k] < max_c[k]) m_fail[k]++;
          if (!m_ffv[k]) begin
            m_ffv[k]   = 1'b1;
            m_ffvec[k] = sb[i].vec;
            m_ffgot[k] = sb[i].got;
          end
`ifdef MINTERM_CHK_STOP_ON_FAIL_EN
          stopped[k]  = 1'b1;
          done_due[k] = cyc;
          drop[k]     = 1'b1;
`endif
        end
      end
      sb = keep;
      for (int j = 0; j < N; j++) begin
        if (pend_start[j]) begin
          clear_model(j);
          started[j]    = 1'b1;
          pend_start[j] = 1'b0;
        end
      end
    end
    #1;
    check_all();
  endtask

  // Drive one cycle of stimulus on instance k (k < 0: all idle).
  task automatic drive(int k, bit st, bit vv, logic [3:0] v);
    logic got;
    for (int j = 0; j < N; j++) begin
      start[j]     = 1'b0;
      vec_valid[j] = 1'b0;
      vec_in[j]    = 4'd0;
    end
    if (k >= 0) begin
      start[k]     = st;
      vec_valid[k] = vv;
      vec_in[k]    = v;
      if (rst_n) begin
        if (st && (!started[k] || m_done(k))) begin
          pend_start[k] = 1'b1;
        end else if (vv && started[k] && !m_done(k) && !stopped[k] &&
                     (m_acc[k] < nv_c[k])) begin
          m_acc[k]++;
          got = dut_model(fault_mode[k], v);
          sb.push_back('{k: k, due: cyc + 1 + lat_c[k], vec: v, got: got,
                         match: (got == truth[v])});
          if (m_acc[k] == nv_c[k])
            done_due[k] = cyc + 1 + ((lat_c[k] > 1) ? lat_c[k] : 1);
        end
      end
    end
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(-1, 1'b0, 1'b0, 4'd0);
  endtask

  // ---------------- directed sequence ----------------
  int seq [19] = '{1, 0, 11, 4, 2, 5, 3, 8, 6, 10, 7, 12, 9, 5, 13, 8, 14, 10, 15};
  int ones [6] = '{0, 4, 5, 8, 10, 12};

  initial begin
    truth = '0;
    foreach (ones[i]) truth[ones[i]] = 1'b1;
    cyc = 0;
    n_checks = 0;
    n_err = 0;
    for (int k = 0; k < N; k++) begin
      fault_mode[k] = 0;
      clear_model(k);
      started[k]    = 1'b0;
      pend_start[k] = 1'b0;
    end

    // Reset: everything cleared, all IDLE.
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Reset in the middle of a run throws everything away.
    drive(0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) drive(0, 1'b0, 1'b1, 4'(seq[i]));
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);

    // Full correct run; a start pulse mid-run must be ignored.
    drive(0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 19; i++) drive(0, i == 9, 1'b1, 4'(seq[i]));
    idle(3);
    check("i0 end pass", 32'(pass_a), 32'd19);
    check("i0 end fail", 32'(fail_a), 32'd0);
    check("i0 end done", 32'(done[0]), 32'd1);

    // Restart from DONE (companion vec_valid dropped), vectors with gaps.
    drive(0, 1'b1, 1'b1, 4'd7);
    for (int i = 0; i < 19; i++) begin
      drive(0, 1'b0, 1'b1, 4'(seq[i]));
      if (i % 4 == 3) idle(1);
    end
    idle(2);
    check("i0 rerun pass", 32'(pass_a), 32'd19);

    // LAT=2, f(4) stuck at 0.
    fault_mode[1] = 1;
    drive(1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 19; i++) drive(1, 1'b0, 1'b1, 4'(seq[i]));
    idle(4);
`ifdef MINTERM_CHK_STOP_ON_FAIL_EN
    check("i1 end pass", 32'(pass_b), 32'd3);
`else
    check("i1 end pass", 32'(pass_b), 32'd18);
`endif
    check("i1 end fail", 32'(fail_b), 32'd1);
    check("i1 end ff_vec", 32'(ffvec[1]), 32'd4);
    check("i1 end ff_got", 32'(ffgot[1]), 32'd0);

    // NUM_VEC=3, inverted output, a 4th vector that must be ignored.
    fault_mode[3] = 2;
    drive(3, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) drive(3, 1'b0, 1'b1, 4'(i));
    idle(2);
`ifdef MINTERM_CHK_STOP_ON_FAIL_EN
    check("i3 end fail", 32'(fail_d), 32'd1);
`else
    check("i3 end fail", 32'(fail_d), 32'd3);
`endif
    check("i3 end ff_vec", 32'(ffvec[3]), 32'd0);

    // CW=2: five passes saturate pass_cnt at 3.
    drive(2, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) drive(2, 1'b0, 1'b1, 4'(seq[i]));
    idle(3);
    check("i2 sat pass", 32'(pass_c), 32'd3);

    // Same instance, fault on the 3rd vector (11).
    fault_mode[2] = 3;
    drive(2, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 7; i++) drive(2, 1'b0, 1'b1, 4'(seq[i]));
    idle(3);
`ifdef MINTERM_CHK_STOP_ON_FAIL_EN
    check("i2 stop pass", 32'(pass_c), 32'd2);
`else
    check("i2 stop pass", 32'(pass_c), 32'd3);
`endif
    check("i2 stop fail", 32'(fail_c), 32'd1);
    check("i2 stop ff_vec", 32'(ffvec[2]), 32'd11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/minterm_resp_checker.md
Name: minterm_resp_checker

Overview:
- Sequential response checker for the 4-input minterm function blocks: the receiving end of the vector stream that drives {a,b,c,d} into a minterm DUT.
- Accepts each applied 4-bit vector and samples the DUT output LAT cycles later.
- Compares the sample against a parameterised 16-entry truth table and accumulates pass/fail statistics.
- Captures the first failing vector and reports done after a programmed number of vectors, so regressions are self-checking instead of judged from waveforms.

Parameters:
- TRUTH, 16'h1531, expected output per vector index; bit i = f(i), with {a,b,c,d} = i and a as MSB. Default = 1 for 0,4,5,8,10,12.
- LAT, 0, DUT latency in cycles from vector applied to dut_out valid; legal range 0..3.
- NUM_VEC, 19, vectors accepted per run; legal range 1..255.
- CW, 8, width of the pass/fail counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a run and clears all results
- vec_valid  in  1  a vector is applied to the DUT this cycle
- vec_in  in  4  applied vector, {a,b,c,d}
- dut_out  in  1  DUT function output
- busy  out  1  high in RUN and DRAIN
- done  out  1  level, high in DONE
- pass_cnt  out  CW  number of matching samples
- fail_cnt  out  CW  number of mismatching samples
- first_fail_vld  out  1  a first failure has been captured
- first_fail_vec  out  4  vector of the first failure
- first_fail_got  out  1  dut_out value seen at the first failure

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. While rst_n=0 at a rising edge, all outputs, counters and the delay line clear to 0 and the state goes to IDLE. Reset mid-run aborts the run and keeps no results.
- States: IDLE, RUN, DRAIN, DONE. Encode them in a 2-bit state register.
- IDLE: on start go to RUN. Clear the counters, first_fail_* and the accepted-vector count. A vec_valid in the same cycle as start is ignored.
- RUN: each vec_valid increments the accepted count (acc_cnt) and pushes {1, vec_in} into a LAT-deep delay line. When acc_cnt reaches NUM_VEC, go to DRAIN on the same edge as the last accept. start is ignored in RUN.
- DRAIN: vec_valid is ignored. Go to DONE when no valid entries remain in the delay line; if LAT=0, go to DONE on the next edge.
- DONE: all results hold stable. start clears the results and returns to RUN, as from IDLE.
- Compare point:
  - LAT=0: compare in the same cycle as vec_valid, using vec_in directly.
  - LAT>0: compare when the delay-line output entry is valid.
  - Entries still in flight during DRAIN are compared normally.
- Check: expected = TRUTH[vec]. On a match, pass_cnt increments; otherwise fail_cnt increments. Counters update at the edge that ends the compare cycle.
- First failure: on the first mismatch of a run, latch first_fail_vec and first_fail_got and set first_fail_vld. Later mismatches do not change these values.
- Counter saturation: each counter saturates at 2^CW-1 and does not wrap.
- No back-pressure: the checker accepts every vec_valid in RUN.

Optional Feature:
- Macro: MINTERM_CHK_STOP_ON_FAIL_EN.
- When defined: the first mismatch forces DONE on the next edge, from either RUN or DRAIN. In-flight entries are discarded and uncounted, and further vec_valid is ignored.
- When undefined: mismatches only count, and the run always completes NUM_VEC vectors.

Decomposition:
- Package minterm_chk_pkg:
  - state enum values (IDLE=0, RUN=1, DRAIN=2, DONE=3)
  - vector width constant VW=4
  - default truth-table constant 16'h1531
- Sub-module chk_delay_line: LAT-deep shift register of {valid, vec[3:0]} with clear input, plus an any-valid flag for the DRAIN exit.
- Top module holds the FSM, compare logic, counters and first-fail capture.

Test Plan:
- Correct DUT model, LAT=0. Apply the 19-vector sequence 1,0,11,4,2,5,3,8,6,10,7,12,9,5,13,8,14,10,15. Required: pass_cnt=19, fail_cnt=0, first_fail_vld=0, done=1 one cycle after the last vector.
- Faulty DUT model, LAT=2, f(4) stuck at 0. Same sequence. Required: fail_cnt=1, pass_cnt=18, first_fail_vec=4'd4, first_fail_got=0. done asserts only after the 2-cycle drain.
- Inverted DUT output, NUM_VEC=3, vectors 0,1,2. Required: fail_cnt=3, first_fail_vec=0. A 4th vec_valid after the 3rd is ignored.
- rst_n=0 after 5 vectors in RUN. Required: next cycle all outputs are 0 and the state is IDLE. Then start plus 19 correct vectors gives pass_cnt=19.
- start pulsed in DONE, and start pulsed mid-RUN. Required: the DONE pulse clears the results and restarts; the mid-RUN pulse has no effect. With CW=2 and NUM_VEC=5, all passing, pass_cnt saturates at 3.
- MINTERM_CHK_STOP_ON_FAIL_EN defined, LAT=1, fault at vector 3 of 19. Required: done the edge after the mismatch, fail_cnt=1, pass_cnt=2.
